// File: rtl/loop_mem_sched.sv
// loop_mem_sched -- per-sample memory scheduler for the looper sample store.
//
// On every audio sample tick the block walks all banks in ascending order:
// recording banks get the captured ADC sample written at the shared loop
// position, playing banks are read and summed into one mix sample. Between
// ticks it runs zero-fill sweeps for bank deletes. It owns the shared loop
// position and the loop length (current_max, 0 = unset).
//
// Ports:
//   clk100, rst          clock, synchronous active-high reset
//   sample_tick          one-cycle pulse at audio rate, rec_data valid with it
//   playing, recording   per-bank enables (recording wins when both are set)
//   delete/delete_bank   level delete request; delete_clear pulses when done
//   set_max, reset_max   latch / clear the loop length
//   mem_*                single-outstanding req/ack memory port, addr={bank,pos}
//   mix_out/mix_valid    mixed playback sample with its one-cycle strobe
//   overrun              sticky, set when a tick had to be dropped
//
// Build option: define MIX_SAT_EN to saturate the mix to the DATA_W range;
// without it the mix wraps in two's complement.
module loop_mem_sched #(
   parameter int NBANKS = 8,
   parameter int BANK_W = 3,
   parameter int POS_W  = 23,
   parameter int DATA_W = 16
) (
   input  logic                    clk100,
   input  logic                    rst,
   input  logic                    sample_tick,
   input  logic [DATA_W-1:0]       rec_data,
   input  logic [NBANKS-1:0]       playing,
   input  logic [NBANKS-1:0]       recording,
   input  logic                    delete,
   input  logic [BANK_W-1:0]       delete_bank,
   output logic                    delete_clear,
   input  logic                    set_max,
   input  logic                    reset_max,
   output logic [POS_W-1:0]        current_max,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [BANK_W+POS_W-1:0] mem_addr,
   output logic [DATA_W-1:0]       mem_wdata,
   input  logic                    mem_ack,
   input  logic [DATA_W-1:0]       mem_rdata,
   output logic [DATA_W-1:0]       mix_out,
   output logic                    mix_valid,
   output logic                    overrun
);

   localparam int ACC_W = DATA_W + BANK_W;

   typedef enum logic [2:0] {
      IDLE, SCAN, ISSUE, WAIT, DONE, DEL_ISSUE, DEL_WAIT
   } state_t;

   state_t                    state_reg, state_next;
   logic [POS_W-1:0]          pos_reg, cmax_reg;
   logic                      tick_pend_reg;
   logic [DATA_W-1:0]         pend_data_reg, sample_reg;
   logic [BANK_W-1:0]         idx_reg;
   logic signed [ACC_W-1:0]   acc_reg;
   logic                      del_active_reg, del_armed_reg;
   logic [BANK_W-1:0]         del_bank_reg;
   logic [POS_W-1:0]          del_pos_reg;
   logic                      set_max_pend_reg;
   logic [DATA_W-1:0]         mix_out_reg;
   logic                      mix_valid_reg, del_clear_reg, overrun_reg;
   logic                      mem_we_reg;
   logic [BANK_W+POS_W-1:0]   mem_addr_reg;
   logic [DATA_W-1:0]         mem_wdata_reg;

   logic                      bank_active, last_bank, del_last, del_start, tick_take;
   logic [POS_W-1:0]          pos_inc;
   logic [DATA_W-1:0]         mix_next;

   assign bank_active = recording[idx_reg] | playing[idx_reg];
   assign last_bank   = (idx_reg == BANK_W'(NBANKS-1));
   // Sweep covers the loop length, or the whole bank when no length is set.
   assign del_last    = (cmax_reg == '0) ? (&del_pos_reg)
                                         : (del_pos_reg == cmax_reg - POS_W'(1));
   assign del_start   = delete && del_armed_reg && !del_active_reg;
   assign tick_take   = (state_reg == IDLE) && tick_pend_reg;
   assign pos_inc     = pos_reg + POS_W'(1);

`ifdef MIX_SAT_EN
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(BANK_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(BANK_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
   always_comb begin
      mix_next = acc_reg[DATA_W-1:0];
      if (acc_reg > SAT_MAX)
         mix_next = SAT_MAX[DATA_W-1:0];
      else if (acc_reg < SAT_MIN)
         mix_next = SAT_MIN[DATA_W-1:0];
   end
`else
   always_comb begin
      mix_next = acc_reg[DATA_W-1:0];
   end
`endif

   // Next-state logic and the request strobe.
   always_comb begin
      state_next = state_reg;
      mem_req    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (tick_pend_reg)
               state_next = SCAN;
            else if (del_active_reg || del_start)
               state_next = DEL_ISSUE;
         end
         SCAN: begin
            if (bank_active)
               state_next = ISSUE;
            else if (last_bank)
               state_next = DONE;
         end
         ISSUE: state_next = WAIT;
         WAIT: begin
            mem_req = 1'b1;
            if (mem_ack)
               state_next = last_bank ? DONE : SCAN;
         end
         DONE:      state_next = IDLE;
         DEL_ISSUE: state_next = DEL_WAIT;
         DEL_WAIT: begin
            mem_req = 1'b1;
            // Returning to IDLE after every word lets a pending tick cut in.
            if (mem_ack)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk100) begin
      if (rst) begin
         state_reg        <= IDLE;
         pos_reg          <= '0;
         cmax_reg         <= '0;
         tick_pend_reg    <= 1'b0;
         pend_data_reg    <= '0;
         sample_reg       <= '0;
         idx_reg          <= '0;
         acc_reg          <= '0;
         del_active_reg   <= 1'b0;
         del_armed_reg    <= 1'b1;
         del_bank_reg     <= '0;
         del_pos_reg      <= '0;
         set_max_pend_reg <= 1'b0;
         mix_out_reg      <= '0;
         mix_valid_reg    <= 1'b0;
         del_clear_reg    <= 1'b0;
         overrun_reg      <= 1'b0;
         mem_we_reg       <= 1'b0;
         mem_addr_reg     <= '0;
         mem_wdata_reg    <= '0;
      end else begin
         state_reg     <= state_next;
         mix_valid_reg <= 1'b0;
         del_clear_reg <= 1'b0;

         // One-deep tick buffer; a tick that finds it still full is dropped.
         if (sample_tick) begin
            if (tick_pend_reg && !tick_take) begin
               overrun_reg <= 1'b1;
            end else begin
               tick_pend_reg <= 1'b1;
               pend_data_reg <= rec_data;
            end
         end else if (tick_take) begin
            tick_pend_reg <= 1'b0;
         end

         if (!delete)
            del_armed_reg <= 1'b1;

         case (state_reg)
            IDLE: begin
               if (tick_pend_reg) begin
                  sample_reg <= pend_data_reg;
                  idx_reg    <= '0;
                  acc_reg    <= '0;
               end else if (del_start) begin
                  del_active_reg <= 1'b1;
                  del_bank_reg   <= delete_bank;
                  del_pos_reg    <= '0;
               end
            end
            SCAN: begin
               if (!bank_active && !last_bank)
                  idx_reg <= idx_reg + BANK_W'(1);
            end
            ISSUE: begin
               mem_addr_reg  <= {idx_reg, pos_reg};
               mem_we_reg    <= recording[idx_reg];
               mem_wdata_reg <= sample_reg;
            end
            WAIT: begin
               if (mem_ack) begin
                  if (!mem_we_reg)
                     acc_reg <= acc_reg + {{BANK_W{mem_rdata[DATA_W-1]}}, mem_rdata};
                  if (!last_bank)
                     idx_reg <= idx_reg + BANK_W'(1);
               end
            end
            DONE: begin
               mix_out_reg   <= mix_next;
               mix_valid_reg <= 1'b1;
            end
            DEL_ISSUE: begin
               mem_addr_reg  <= {del_bank_reg, del_pos_reg};
               mem_we_reg    <= 1'b1;
               mem_wdata_reg <= '0;
            end
            DEL_WAIT: begin
               if (mem_ack) begin
                  if (del_last) begin
                     del_clear_reg  <= 1'b1;
                     del_active_reg <= 1'b0;
                     // Held-high delete must drop before another sweep starts.
                     del_armed_reg  <= 1'b0;
                  end else begin
                     del_pos_reg <= del_pos_reg + POS_W'(1);
                  end
               end
            end
            default: ;
         endcase

         // Loop position / length. A set_max request is parked until the next
         // DONE so the length is taken from the position just processed.
         if (reset_max) begin
            cmax_reg         <= '0;
            pos_reg          <= '0;
            set_max_pend_reg <= 1'b0;
         end else if (state_reg == DONE) begin
            if (set_max || set_max_pend_reg) begin
               cmax_reg         <= pos_inc;
               pos_reg          <= '0;
               set_max_pend_reg <= 1'b0;
            end else if (cmax_reg == '0) begin
               if (!(&pos_reg))
                  pos_reg <= pos_inc;
            end else begin
               pos_reg <= (pos_inc == cmax_reg) ? '0 : pos_inc;
            end
         end else if (set_max) begin
            set_max_pend_reg <= 1'b1;
         end
      end
   end

   assign delete_clear = del_clear_reg;
   assign current_max  = cmax_reg;
   assign mem_we       = mem_we_reg;
   assign mem_addr     = mem_addr_reg;
   assign mem_wdata    = mem_wdata_reg;
   assign mix_out      = mix_out_reg;
   assign mix_valid    = mix_valid_reg;
   assign overrun      = overrun_reg;

endmodule

// File: tb/tb_loop_mem_sched.sv
// Directed bench for loop_mem_sched: a table of per-tick vectors plus
// hand-written sequences for delete sweeps, overrun and reset mid-sweep.
module tb_loop_mem_sched;

   logic        clk100 = 1'b0;
   logic        rst = 1'b1;
   logic        sample_tick = 1'b0;
   logic [15:0] rec_data = '0;
   logic [7:0]  playing = '0;
   logic [7:0]  recording = '0;
   logic        delete = 1'b0;
   logic [2:0]  delete_bank = '0;
   logic        delete_clear;
   logic        set_max = 1'b0;
   logic        reset_max = 1'b0;
   logic [22:0] current_max;
   logic        mem_req;
   logic        mem_we;
   logic [25:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic [15:0] mix_out;
   logic        mix_valid;
   logic        overrun;

   loop_mem_sched dut (
      .clk100(clk100), .rst(rst), .sample_tick(sample_tick), .rec_data(rec_data),
      .playing(playing), .recording(recording), .delete(delete),
      .delete_bank(delete_bank), .delete_clear(delete_clear), .set_max(set_max),
      .reset_max(reset_max), .current_max(current_max), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mix_out(mix_out),
      .mix_valid(mix_valid), .overrun(overrun)
   );

   always #5 clk100 = ~clk100;

`ifdef MIX_SAT_EN
   localparam logic [15:0] MIX_BIG_POS = 16'h7FFF;
   localparam logic [15:0] MIX_BIG_NEG = 16'h8000;
`else
   localparam logic [15:0] MIX_BIG_POS = 16'hE000;
   localparam logic [15:0] MIX_BIG_NEG = 16'h2000;
`endif

   int n_cmp = 0;
   int n_fail = 0;

   // Memory model / monitors (cumulative counters, only written here).
   logic [15:0] rd_value = '0;
   int          ack_delay = 0;
   logic        ack_en = 1'b1;
   int          n_ops = 0, n_w = 0, n_r = 0;
   logic [25:0] last_addr = '0;
   logic [15:0] last_wdata = '0;
   logic [25:0] log_addr [256];
   logic        log_we   [256];
   logic [15:0] log_wd   [256];
   int          clr_cnt = 0, mv_cnt = 0;

   initial begin
      int wait_cnt;
      wait_cnt  = 0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk100);
         #1;
         mem_rdata = rd_value;
         if (mem_ack) begin
            mem_ack = 1'b0;
         end else if (mem_req && ack_en) begin
            if (wait_cnt >= ack_delay) begin
               mem_ack  = 1'b1;
               wait_cnt = 0;
               if (mem_we) begin
                  n_w++;
                  last_wdata = mem_wdata;
               end else begin
                  n_r++;
               end
               last_addr = mem_addr;
               if (n_ops < 256) begin
                  log_addr[n_ops] = mem_addr;
                  log_we[n_ops]   = mem_we;
                  log_wd[n_ops]   = mem_wdata;
               end
               n_ops++;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk100);
         #1;
         if (delete_clear) clr_cnt++;
         if (mix_valid)    mv_cnt++;
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk100);
         #1;
      end
   endtask

   task automatic do_tick(input logic [15:0] d, input logic sm);
      @(posedge clk100);
      #1;
      sample_tick = 1'b1;
      rec_data    = d;
      set_max     = sm;
      @(posedge clk100);
      #1;
      sample_tick = 1'b0;
      set_max     = 1'b0;
   endtask

   task automatic wait_mix(output logic found);
      found = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk100);
         #1;
         if (mix_valid) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   typedef struct packed {
      logic        pre_rmax;
      logic        smax;
      logic [15:0] d;
      logic [7:0]  rec;
      logic [7:0]  play;
      logic [15:0] rdata;
      logic [15:0] exp_mix;
      logic [3:0]  exp_w;
      logic [3:0]  exp_r;
      logic [25:0] exp_addr;
      logic [15:0] exp_wdata;
      logic [22:0] exp_pos;
      logic [22:0] exp_cmax;
   } vec_t;

   function automatic vec_t mk(input logic pr, input logic sm, input logic [15:0] d,
                               input logic [7:0] rec, input logic [7:0] play,
                               input logic [15:0] rdata, input logic [15:0] em,
                               input logic [3:0] ew, input logic [3:0] er,
                               input logic [2:0] ab, input logic [22:0] ap,
                               input logic [15:0] ewd, input logic [22:0] ep,
                               input logic [22:0] ec);
      vec_t v;
      v.pre_rmax = pr;  v.smax = sm;  v.d = d;  v.rec = rec;  v.play = play;
      v.rdata = rdata;  v.exp_mix = em;  v.exp_w = ew;  v.exp_r = er;
      v.exp_addr = {ab, ap};  v.exp_wdata = ewd;  v.exp_pos = ep;  v.exp_cmax = ec;
      return v;
   endfunction

   vec_t vecs [19];

   initial begin
      logic found;
      int   b_ops, b_w, b_r, b_clr, b_mv, k;
      string tag;

      // Expected values worked out by hand from the loop/mix rules.
      vecs[0]  = mk(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 16'h0000, 16'h0000, 4'd0, 4'd0, 3'd0, 23'd0, 16'h0000, 23'd1, 23'd0);
      vecs[1]  = mk(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 16'h0000, 16'h0000, 4'd0, 4'd0, 3'd0, 23'd0, 16'h0000, 23'd2, 23'd0);
      vecs[2]  = mk(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 16'h0000, 16'h0000, 4'd0, 4'd0, 3'd0, 23'd0, 16'h0000, 23'd3, 23'd0);
      vecs[3]  = mk(1'b1, 1'b0, 16'h0100, 8'h01, 8'h00, 16'h0000, 16'h0000, 4'd1, 4'd0, 3'd0, 23'd0, 16'h0100, 23'd1, 23'd0);
      vecs[4]  = mk(1'b0, 1'b0, 16'h0100, 8'h01, 8'h00, 16'h0000, 16'h0000, 4'd1, 4'd0, 3'd0, 23'd1, 16'h0100, 23'd2, 23'd0);
      vecs[5]  = mk(1'b0, 1'b0, 16'h0100, 8'h01, 8'h00, 16'h0000, 16'h0000, 4'd1, 4'd0, 3'd0, 23'd2, 16'h0100, 23'd3, 23'd0);
      vecs[6]  = mk(1'b0, 1'b0, 16'h0100, 8'h01, 8'h00, 16'h0000, 16'h0000, 4'd1, 4'd0, 3'd0, 23'd3, 16'h0100, 23'd4, 23'd0);
      vecs[7]  = mk(1'b0, 1'b1, 16'h0100, 8'h01, 8'h00, 16'h0000, 16'h0000, 4'd1, 4'd0, 3'd0, 23'd4, 16'h0100, 23'd0, 23'd5);
      vecs[8]  = mk(1'b0, 1'b0, 16'h0100, 8'h01, 8'h00, 16'h0000, 16'h0000, 4'd1, 4'd0, 3'd0, 23'd0, 16'h0100, 23'd1, 23'd5);
      vecs[9]  = mk(1'b0, 1'b0, 16'h0100, 8'h01, 8'h00, 16'h0000, 16'h0000, 4'd1, 4'd0, 3'd0, 23'd1, 16'h0100, 23'd2, 23'd5);
      vecs[10] = mk(1'b0, 1'b0, 16'h0100, 8'h01, 8'h00, 16'h0000, 16'h0000, 4'd1, 4'd0, 3'd0, 23'd2, 16'h0100, 23'd3, 23'd5);
      vecs[11] = mk(1'b0, 1'b0, 16'h0100, 8'h01, 8'h00, 16'h0000, 16'h0000, 4'd1, 4'd0, 3'd0, 23'd3, 16'h0100, 23'd4, 23'd5);
      vecs[12] = mk(1'b0, 1'b0, 16'h0100, 8'h01, 8'h00, 16'h0000, 16'h0000, 4'd1, 4'd0, 3'd0, 23'd4, 16'h0100, 23'd0, 23'd5);
      vecs[13] = mk(1'b0, 1'b0, 16'h0100, 8'h01, 8'h00, 16'h0000, 16'h0000, 4'd1, 4'd0, 3'd0, 23'd0, 16'h0100, 23'd1, 23'd5);
      vecs[14] = mk(1'b0, 1'b0, 16'h0000, 8'h00, 8'h06, 16'h7000, MIX_BIG_POS, 4'd0, 4'd2, 3'd2, 23'd1, 16'h0000, 23'd2, 23'd5);
      vecs[15] = mk(1'b0, 1'b0, 16'h0000, 8'h00, 8'h06, 16'h9000, MIX_BIG_NEG, 4'd0, 4'd2, 3'd2, 23'd2, 16'h0000, 23'd3, 23'd5);
      vecs[16] = mk(1'b0, 1'b0, 16'h0000, 8'h00, 8'h01, 16'h1234, 16'h1234, 4'd0, 4'd1, 3'd0, 23'd3, 16'h0000, 23'd4, 23'd5);
      vecs[17] = mk(1'b0, 1'b0, 16'hBEEF, 8'h01, 8'h01, 16'h0000, 16'h0000, 4'd1, 4'd0, 3'd0, 23'd4, 16'hBEEF, 23'd0, 23'd5);
      vecs[18] = mk(1'b0, 1'b0, 16'h5555, 8'h80, 8'h81, 16'h0010, 16'h0010, 4'd1, 4'd1, 3'd7, 23'd0, 16'h5555, 23'd1, 23'd5);

      // ---- reset values ----
      cycles(3);
      rst = 1'b0;
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mix_valid", 32'(mix_valid), 32'd0);
      check("rst_mix_out", 32'(mix_out), 32'd0);
      check("rst_cmax", 32'(current_max), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      check("rst_del_clear", 32'(delete_clear), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_pos", 32'(dut.pos_reg), 32'd0);

      // ---- table-driven ticks ----
      for (int i = 0; i < 19; i++) begin
         recording = vecs[i].rec;
         playing   = vecs[i].play;
         rd_value  = vecs[i].rdata;
         if (vecs[i].pre_rmax) begin
            @(posedge clk100);
            #1 reset_max = 1'b1;
            @(posedge clk100);
            #1 reset_max = 1'b0;
         end
         cycles(1);
         b_w = n_w;
         b_r = n_r;
         do_tick(vecs[i].d, vecs[i].smax);
         wait_mix(found);
         check($sformatf("v%0d_mix_seen", i), 32'(found), 32'd1);
         check($sformatf("v%0d_mix", i), 32'(mix_out), 32'(vecs[i].exp_mix));
         check($sformatf("v%0d_nwrites", i), 32'(n_w - b_w), 32'(vecs[i].exp_w));
         check($sformatf("v%0d_nreads", i), 32'(n_r - b_r), 32'(vecs[i].exp_r));
         if (vecs[i].exp_w + vecs[i].exp_r != 4'd0)
            check($sformatf("v%0d_addr", i), 32'(last_addr), 32'(vecs[i].exp_addr));
         if (vecs[i].exp_w != 4'd0)
            check($sformatf("v%0d_wdata", i), 32'(last_wdata), 32'(vecs[i].exp_wdata));
         check($sformatf("v%0d_pos", i), 32'(dut.pos_reg), 32'(vecs[i].exp_pos));
         check($sformatf("v%0d_cmax", i), 32'(current_max), 32'(vecs[i].exp_cmax));
         $display("vec %0d: rec=%h play=%h mix=%h pos=%0d cmax=%0d",
                  i, vecs[i].rec, vecs[i].play, mix_out, dut.pos_reg, current_max);
      end

      // ---- loop length 4: clear, 3 idle ticks, set_max on the 4th ----
      recording = '0;
      playing   = '0;
      @(posedge clk100);
      #1 reset_max = 1'b1;
      @(posedge clk100);
      #1 reset_max = 1'b0;
      for (int i = 0; i < 4; i++) begin
         do_tick(16'h0000, (i == 3) ? 1'b1 : 1'b0);
         wait_mix(found);
      end
      check("cmax4", 32'(current_max), 32'd4);
      check("cmax4_pos", 32'(dut.pos_reg), 32'd0);
      $display("set loop length: cmax=%0d", current_max);

      // ---- delete sweep of bank 2 with a tick injected mid-sweep ----
      b_ops = n_ops;
      b_clr = clr_cnt;
      b_mv  = mv_cnt;
      @(posedge clk100);
      #1;
      delete_bank = 3'd2;
      delete      = 1'b1;
      k = 0;
      while (n_ops - b_ops < 1 && k < 100) begin
         cycles(1);
         k++;
      end
      check("del_first_word", 32'(n_ops - b_ops >= 1), 32'd1);
      do_tick(16'h1111, 1'b0);
      k = 0;
      while (clr_cnt == b_clr && k < 300) begin
         cycles(1);
         k++;
      end
      check("del_clear_seen", 32'(clr_cnt - b_clr), 32'd1);
      check("del_nwords", 32'(n_ops - b_ops), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("del_addr%0d", i), 32'(log_addr[b_ops + i]), 32'({3'd2, 23'(i)}));
         check($sformatf("del_we%0d", i), 32'(log_we[b_ops + i]), 32'd1);
         check($sformatf("del_wd%0d", i), 32'(log_wd[b_ops + i]), 32'd0);
      end
      check("del_tick_served", 32'(mv_cnt - b_mv), 32'd1);
      cycles(20);
      check("del_no_restart_ops", 32'(n_ops - b_ops), 32'd4);
      check("del_single_clear", 32'(clr_cnt - b_clr), 32'd1);
      $display("delete sweep: words=%0d clears=%0d ticks=%0d",
               n_ops - b_ops, clr_cnt - b_clr, mv_cnt - b_mv);
      delete = 1'b0;
      cycles(2);

      // ---- stalled memory: overrun ----
      recording = 8'h01;
      ack_en    = 1'b0;
      do_tick(16'h2222, 1'b0);
      cycles(12);
      do_tick(16'h3333, 1'b0);
      do_tick(16'h4444, 1'b0);
      cycles(5);
      check("ovr_set", 32'(overrun), 32'd1);
      check("ovr_req_held", 32'(mem_req), 32'd1);
      ack_en = 1'b1;
      cycles(60);
      check("ovr_sticky", 32'(overrun), 32'd1);
      check("ovr_req_idle", 32'(mem_req), 32'd0);
      $display("overrun: overrun=%0d mem_req=%0d", overrun, mem_req);
      recording = '0;

      // ---- reset in the middle of a slow sweep ----
      ack_delay   = 3;
      b_ops       = n_ops;
      b_clr       = clr_cnt;
      delete_bank = 3'd3;
      delete      = 1'b1;
      k = 0;
      while (n_ops - b_ops < 2 && k < 200) begin
         cycles(1);
         k++;
      end
      check("rmid_words_before", 32'(n_ops - b_ops >= 2), 32'd1);
      k = 0;
      while (!mem_req && k < 50) begin
         cycles(1);
         k++;
      end
      rst    = 1'b1;
      delete = 1'b0;
      cycles(1);
      check("rmid_req_drop", 32'(mem_req), 32'd0);
      rst = 1'b0;
      check("rmid_overrun_clr", 32'(overrun), 32'd0);
      cycles(20);
      check("rmid_no_clear", 32'(clr_cnt - b_clr), 32'd0);
      check("rmid_idle_req", 32'(mem_req), 32'd0);
      $display("reset mid-sweep: mem_req=%0d clears=%0d", mem_req, clr_cnt - b_clr);
      ack_delay = 0;

      tag = "";
      $display("*** SUMMARY: %0d compared / %0d mismatched ***%s", n_cmp, n_fail, tag);
      $finish;
   end

   // Hard stop in case a wait above misbehaves.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
